// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch buttons, stopwatch_ctrl and the downstream timer_counter.
// Contract: btn_* are raw asynchronous levels (1 = pressed); en_1ms and clear_en are one-clock
// pulses; start_en is a level that is high exactly while state reads RUN (2'b01).
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       en_1ms;
  logic       start_en;
  logic       clear_en;
  logic [1:0] state;

  modport master (
    output btn_start, btn_clear,
    input  en_1ms, start_en, clear_en, state
  );

  modport slave (
    input  btn_start, btn_clear,
    output en_1ms, start_en, clear_en, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: 1 ms prescaler, button sync/debounce and IDLE/RUN/PAUSE FSM.
// Optional macro STOPWATCH_CLR_IN_RUN_EN lets CLEAR abort a running count straight to IDLE.
module stopwatch_ctrl #(
  parameter int CLK_PER_MS  = 16,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  logic [PW-1:0] pre_cnt;
  logic          en_1ms;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_d;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    press;
  state_t        state;
  logic          start_en;
  logic          clear_en;

  // en_1ms is high while pre_cnt reads CLK_PER_MS-1, i.e. registered one count early.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      en_1ms  <= 1'b0;
    end else begin
      if (pre_cnt == PW'(CLK_PER_MS - 1)) pre_cnt <= '0;
      else                                pre_cnt <= pre_cnt + 1'b1;
      en_1ms <= (pre_cnt == PW'(CLK_PER_MS - 2));
    end
  end

  // Bit 0 is START, bit 1 is CLEAR; both paths are identical.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_d   <= '0;
      db_cnt <= '{default: '0};
    end else begin
      sync1 <= {sw.btn_clear, sw.btn_start};
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (en_1ms) begin
          if (db_cnt[i] == CW'(DEBOUNCE_MS - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign press = db & ~db_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      start_en <= 1'b0;
      clear_en <= 1'b0;
    end else begin
      clear_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press[0]) begin
            state    <= ST_RUN;
            start_en <= 1'b1;
          end
        end
        ST_RUN: begin
`ifdef STOPWATCH_CLR_IN_RUN_EN
          if (press[1]) begin
            state    <= ST_IDLE;
            start_en <= 1'b0;
            clear_en <= 1'b1;
          end else if (press[0]) begin
            state    <= ST_PAUSE;
            start_en <= 1'b0;
          end
`else
          if (press[0]) begin
            state    <= ST_PAUSE;
            start_en <= 1'b0;
          end
`endif
        end
        ST_PAUSE: begin
          if (press[1]) begin
            state    <= ST_IDLE;
            start_en <= 1'b0;
            clear_en <= 1'b1;
          end else if (press[0]) begin
            state    <= ST_RUN;
            start_en <= 1'b1;
          end
        end
        default: begin
          // Only an upset can land here; recover as if a clear had been issued.
          state    <= ST_IDLE;
          start_en <= 1'b0;
          clear_en <= 1'b1;
        end
      endcase
    end
  end

  assign sw.en_1ms   = en_1ms;
  assign sw.start_en = start_en;
  assign sw.clear_en = clear_en;
  assign sw.state    = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with CLK_PER_MS=16, DEBOUNCE_MS=4.
// Build with +define+STOPWATCH_CLR_IN_RUN_EN to exercise the clear-in-RUN variant.
module tb_stopwatch_ctrl;
  localparam int N       = 16;
  localparam int D       = 4;
  localparam int LAT_MIN = 4 + (D - 1) * N;
  localparam int LAT_MAX = 19 + (D - 1) * N;
  localparam int HOLD    = 6 * N;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.CLK_PER_MS(N), .DEBOUNCE_MS(D)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw.slave)
  );

  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;
  logic [2:0] exp_q[$];
  logic [2:0] exp_e;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard monitor: every state change pops one expected {clear_en, state}
  always @(negedge clk) begin
    if (mon_en) begin
      check("start_en_level", int'(sw.start_en), int'(sw.state == S_RUN));
      check("state_legal", int'(sw.state == 2'b11), 0);
      if (sw.state !== prev_state) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", int'(sw.state), int'(prev_state));
        end else begin
          exp_e = exp_q.pop_front();
          check("state_change", int'(sw.state), int'(exp_e[1:0]));
          check("clear_on_change", int'(sw.clear_en), int'(exp_e[2]));
        end
        prev_state <= sw.state;
      end else begin
        check("no_stray_clear", int'(sw.clear_en), 0);
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // must be called right after reset_dut: loop index k is the cycle number after release
  task automatic check_prescaler(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      check("en_1ms", int'(sw.en_1ms), int'((k % N) == 0));
      if (k == 1) begin
        check("post_reset_state", int'(sw.state), 0);
        check("post_reset_start_en", int'(sw.start_en), 0);
        check("post_reset_clear_en", int'(sw.clear_en), 0);
      end
    end
  endtask

  task automatic press(input logic s, input logic c, input logic change,
                       input logic [2:0] exp, input int hold);
    logic [1:0] st0;
    int n;
    @(negedge clk);
    if (change) exp_q.push_back(exp);
    st0 = sw.state;
    sw.btn_start = s;
    sw.btn_clear = c;
    n = 0;
    if (change) begin
      do begin
        @(negedge clk);
        n++;
      end while (sw.state == st0 && n < 100);
      if (sw.state == st0) begin
        check("press_timeout", int'(sw.state), int'(exp[1:0]));
      end else begin
        check("press_latency_in_window", int'(n >= LAT_MIN && n <= LAT_MAX), 1);
      end
    end
    repeat (hold - n) @(negedge clk);
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic glitch(input int ms);
    @(negedge clk);
    sw.btn_start = 1'b1;
    repeat (ms * N) @(negedge clk);
    sw.btn_start = 1'b0;
    repeat (2 * N) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;

    // reset state and free-running prescaler
    reset_dut();
    mon_en = 1'b1;
    check_prescaler(4 * N);

    // held START gives exactly one transition
    press(1'b1, 1'b0, 1'b1, {1'b0, S_RUN}, 10 * N);

    // short pulses never qualify; a release between must restart the count
    glitch(2);
    glitch(1);
    glitch(3);
    glitch(3);

    // CLEAR while running
`ifdef STOPWATCH_CLR_IN_RUN_EN
    press(1'b0, 1'b1, 1'b1, {1'b1, S_IDLE}, HOLD);
    press(1'b1, 1'b0, 1'b1, {1'b0, S_RUN}, HOLD);
`else
    press(1'b0, 1'b1, 1'b0, 3'b000, HOLD);
`endif

    // PAUSE then simultaneous: clear wins
    press(1'b1, 1'b0, 1'b1, {1'b0, S_PAUSE}, HOLD);
    press(1'b1, 1'b1, 1'b1, {1'b1, S_IDLE}, HOLD);

    // IDLE: clear ignored, simultaneous start wins
    press(1'b0, 1'b1, 1'b0, 3'b000, HOLD);
    press(1'b1, 1'b1, 1'b1, {1'b0, S_RUN}, HOLD);

    // RUN: simultaneous events
`ifdef STOPWATCH_CLR_IN_RUN_EN
    press(1'b1, 1'b1, 1'b1, {1'b1, S_IDLE}, HOLD);
    press(1'b0, 1'b1, 1'b0, 3'b000, HOLD);
`else
    press(1'b1, 1'b1, 1'b1, {1'b0, S_PAUSE}, HOLD);
    press(1'b0, 1'b1, 1'b1, {1'b1, S_IDLE}, HOLD);
`endif

    // full START, START, CLEAR sequence
    press(1'b1, 1'b0, 1'b1, {1'b0, S_RUN}, HOLD);
    press(1'b1, 1'b0, 1'b1, {1'b0, S_PAUSE}, HOLD);
    press(1'b0, 1'b1, 1'b1, {1'b1, S_IDLE}, HOLD);

    // reset in RUN with a half-debounced CLEAR pending
    press(1'b1, 1'b0, 1'b1, {1'b0, S_RUN}, HOLD);
    @(negedge clk);
    sw.btn_clear = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back({1'b0, S_IDLE});
    reset_dut();
    check_prescaler(3 * N);
    repeat (6 * N) @(negedge clk);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
